// File: rtl/rv_decode_stage_pkg.sv
// rtl/rv_decode_stage_pkg.sv - shared opcodes, format codes and decoded-entry type
//
// Purpose: constants and types shared by rv_imm_gen and rv_decode_stage.
// Ports:   none (package).

package rv_decode_stage_pkg;

  // Major opcodes (instr[6:0]) recognised by the decoder.
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_ART    = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  // Instruction format classification presented on out_fmt.
  typedef enum logic [2:0] {
    FMT_R    = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5,
    FMT_NONE = 3'd7
  } fmt_e;

  // Width-independent part of one decoded entry; pc and imm are stored
  // beside it because their widths are module parameters.
  typedef struct packed {
    logic [6:0] opcode;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [2:0] funct3;
    logic [6:0] funct7;
    fmt_e       fmt;
    logic       illegal;
    logic       muldiv;
  } dec_t;

endpackage

// File: rtl/rv_imm_gen.sv
// rtl/rv_imm_gen.sv - combinational immediate generator and format classifier
//
// Purpose: derive the sign-extended immediate and the format from a raw
//          instruction word. Legality is not judged here.
// Ports:
//   instr_i  in  32    raw instruction word
//   imm_o    out XLEN  immediate (0 for R / NONE formats)
//   fmt_o    out 3     format code (fmt_e)

module rv_imm_gen
  import rv_decode_stage_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr_i,
  output logic [XLEN-1:0] imm_o,
  output fmt_e            fmt_o
);

  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    return XLEN'($signed(v));
  endfunction

  logic [2:0] funct3;
  logic [5:0] shamt;

  assign funct3 = instr_i[14:12];
  // RV64 shifts use one more shamt bit (instr[25]).
  assign shamt  = (XLEN == 64) ? instr_i[25:20] : {1'b0, instr_i[24:20]};

  always_comb begin
    imm_o = '0;
    fmt_o = FMT_NONE;
    case (instr_i[6:0])
      OPC_LUI, OPC_AUIPC: begin
        fmt_o = FMT_U;
        imm_o = sext32({instr_i[31:12], 12'b0});
      end
      OPC_JAL: begin
        fmt_o = FMT_J;
        imm_o = sext32({{11{instr_i[31]}}, instr_i[31], instr_i[19:12],
                        instr_i[20], instr_i[30:21], 1'b0});
      end
      OPC_JALR, OPC_LOAD: begin
        fmt_o = FMT_I;
        imm_o = sext32({{20{instr_i[31]}}, instr_i[31:20]});
      end
      OPC_IMM: begin
        fmt_o = FMT_I;
        // Shift amounts are unsigned; funct7 bits above shamt must not leak in.
        if (funct3 == 3'b001 || funct3 == 3'b101) begin
          imm_o = XLEN'(shamt);
        end else begin
          imm_o = sext32({{20{instr_i[31]}}, instr_i[31:20]});
        end
      end
      OPC_STORE: begin
        fmt_o = FMT_S;
        imm_o = sext32({{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]});
      end
      OPC_BRANCH: begin
        fmt_o = FMT_B;
        imm_o = sext32({{19{instr_i[31]}}, instr_i[31], instr_i[7],
                        instr_i[30:25], instr_i[11:8], 1'b0});
      end
      OPC_ART: begin
        fmt_o = FMT_R;
      end
      default: begin
        fmt_o = FMT_NONE;
      end
    endcase
  end

endmodule

// File: rtl/rv_decode_stage.sv
// rtl/rv_decode_stage.sv - pipelined RISC-V decode stage with 2-entry skid buffer
//
// Purpose: decode {pc, instr} from fetch, flag illegal encodings and present
//          the result one cycle later through a 2-entry FIFO skid buffer.
// Config:  define DECODE_RVM_EN to accept M-extension OP encodings
//          (funct7 0000001) and drive out_muldiv; otherwise they are illegal.
// Ports:
//   clk, rst_n           clock (rising edge), async active-low reset
//   flush                drop every buffered entry and any same-cycle input
//   in_valid/in_ready    fetch handshake; in_pc, in_instr payload
//   out_valid/out_ready  downstream handshake
//   out_pc .. out_muldiv decoded fields of the head entry (registered)

module rv_decode_stage
  import rv_decode_stage_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int PC_W = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [PC_W-1:0] in_pc,
  input  logic [31:0]     in_instr,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [PC_W-1:0] out_pc,
  output logic [6:0]      out_opcode,
  output logic [4:0]      out_rd,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [2:0]      out_funct3,
  output logic [6:0]      out_funct7,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_fmt,
  output logic            out_illegal,
  output logic            out_muldiv
);

  // ---------------------------------------------------------------------
  // Combinational decode of the incoming word
  // ---------------------------------------------------------------------
  logic [XLEN-1:0] gen_imm;
  fmt_e            gen_fmt;
  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic            illegal_c;
  logic            muldiv_c;
  dec_t            dec_c;
  logic [XLEN-1:0] imm_c;

  rv_imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .instr_i (in_instr),
    .imm_o   (gen_imm),
    .fmt_o   (gen_fmt)
  );

  assign opcode = in_instr[6:0];
  assign funct3 = in_instr[14:12];
  assign funct7 = in_instr[31:25];

  always_comb begin
    illegal_c = 1'b0;
    muldiv_c  = 1'b0;
    case (opcode)
      OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_FENCE, OPC_SYSTEM: illegal_c = 1'b0;
      OPC_JALR:   illegal_c = (funct3 != 3'b000);
      OPC_BRANCH: illegal_c = (funct3 == 3'b010) || (funct3 == 3'b011);
      OPC_LOAD: begin
        // ld (011) and lwu (110) only exist on RV64.
        illegal_c = (funct3 == 3'b111) ||
                    ((XLEN == 32) && ((funct3 == 3'b011) || (funct3 == 3'b110)));
      end
      OPC_STORE:  illegal_c = (XLEN == 64) ? (funct3 > 3'b011) : (funct3 > 3'b010);
      OPC_ART: begin
        if (funct7 == 7'b0000000) begin
          illegal_c = 1'b0;
        end else if (funct7 == 7'b0100000) begin
          // Only sub and sra carry the alternate funct7.
          illegal_c = !((funct3 == 3'b000) || (funct3 == 3'b101));
        end else if (funct7 == 7'b0000001) begin
`ifdef DECODE_RVM_EN
          muldiv_c  = 1'b1;
`else
          illegal_c = 1'b1;
`endif
        end else begin
          illegal_c = 1'b1;
        end
      end
      OPC_IMM: begin
        // On RV64 instr[25] is shamt[5], so only instr[31:26] are checked.
        if (funct3 == 3'b001) begin
          illegal_c = (XLEN == 64) ? (in_instr[31:26] != 6'b000000)
                                   : (funct7 != 7'b0000000);
        end else if (funct3 == 3'b101) begin
          illegal_c = (XLEN == 64)
                    ? !((in_instr[31:26] == 6'b000000) || (in_instr[31:26] == 6'b010000))
                    : !((funct7 == 7'b0000000) || (funct7 == 7'b0100000));
        end
      end
      default: illegal_c = 1'b1;
    endcase
    if (in_instr[1:0] != 2'b11) begin
      illegal_c = 1'b1;
    end
    if (illegal_c) begin
      muldiv_c = 1'b0;
    end
  end

  always_comb begin
    dec_c         = '0;
    dec_c.opcode  = opcode;
    dec_c.funct3  = funct3;
    dec_c.funct7  = funct7;
    dec_c.illegal = illegal_c;
    dec_c.muldiv  = muldiv_c;
    dec_c.fmt     = illegal_c ? FMT_NONE : gen_fmt;
    imm_c         = illegal_c ? '0 : gen_imm;
    // Register fields are reported only where the format actually uses them.
    if (!illegal_c) begin
      case (gen_fmt)
        FMT_R: begin
          dec_c.rd  = in_instr[11:7];
          dec_c.rs1 = in_instr[19:15];
          dec_c.rs2 = in_instr[24:20];
        end
        FMT_I: begin
          dec_c.rd  = in_instr[11:7];
          dec_c.rs1 = in_instr[19:15];
        end
        FMT_S, FMT_B: begin
          dec_c.rs1 = in_instr[19:15];
          dec_c.rs2 = in_instr[24:20];
        end
        FMT_U, FMT_J: begin
          dec_c.rd  = in_instr[11:7];
        end
        default: begin
          dec_c.rd  = 5'd0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // 2-entry skid buffer; slot 0 is the head and drives out_* directly
  // ---------------------------------------------------------------------
  logic [1:0]      count_q, count_d;
  dec_t            ent0_q, ent0_d, ent1_q, ent1_d;
  logic [XLEN-1:0] imm0_q, imm0_d, imm1_q, imm1_d;
  logic [PC_W-1:0] pc0_q, pc0_d, pc1_q, pc1_d;
  logic            push, pop;

  assign in_ready  = (count_q != 2'd2);
  assign out_valid = (count_q != 2'd0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_comb begin
    count_d = count_q;
    ent0_d  = ent0_q;
    ent1_d  = ent1_q;
    imm0_d  = imm0_q;
    imm1_d  = imm1_q;
    pc0_d   = pc0_q;
    pc1_d   = pc1_q;
    if (flush) begin
      count_d = 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count_q == 2'd0) begin
            ent0_d = dec_c;
            imm0_d = imm_c;
            pc0_d  = in_pc;
          end else begin
            ent1_d = dec_c;
            imm1_d = imm_c;
            pc1_d  = in_pc;
          end
          count_d = count_q + 2'd1;
        end
        2'b01: begin
          ent0_d  = ent1_q;
          imm0_d  = imm1_q;
          pc0_d   = pc1_q;
          count_d = count_q - 2'd1;
        end
        2'b11: begin
          // push needs count < 2 and pop needs count > 0, so count is 1:
          // the new entry replaces the departing head.
          ent0_d = dec_c;
          imm0_d = imm_c;
          pc0_d  = in_pc;
        end
        default: begin
          count_d = count_q;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= 2'd0;
      ent0_q  <= '0;
      ent1_q  <= '0;
      imm0_q  <= '0;
      imm1_q  <= '0;
      pc0_q   <= '0;
      pc1_q   <= '0;
    end else begin
      count_q <= count_d;
      ent0_q  <= ent0_d;
      ent1_q  <= ent1_d;
      imm0_q  <= imm0_d;
      imm1_q  <= imm1_d;
      pc0_q   <= pc0_d;
      pc1_q   <= pc1_d;
    end
  end

  assign out_pc      = pc0_q;
  assign out_opcode  = ent0_q.opcode;
  assign out_rd      = ent0_q.rd;
  assign out_rs1     = ent0_q.rs1;
  assign out_rs2     = ent0_q.rs2;
  assign out_funct3  = ent0_q.funct3;
  assign out_funct7  = ent0_q.funct7;
  assign out_imm     = imm0_q;
  assign out_fmt     = ent0_q.fmt;
  assign out_illegal = ent0_q.illegal;
  assign out_muldiv  = ent0_q.muldiv;

endmodule
